// File: rtl/wb_ctrl.sv
`default_nettype none
// ============================================================================
// wb_ctrl: register-file write-port owner; merges EX and long-latency results
// through a pending queue and tracks outstanding long-latency destinations.
// Optional feature macro: WB_BYPASS_EN (direct load of long-latency results).
// Revision: 1.0
// ============================================================================
module wb_ctrl #(
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_waddr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic        ex_wen_i,
  input  logic [4:0]  lu_waddr_i,
  input  logic [31:0] lu_wdata_i,
  input  logic        lu_valid_i,
  output logic        lu_ready_o,
  input  logic [4:0]  iss_rd_i,
  input  logic        iss_long_i,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_rd_i,
  output logic        stall_o,
  output logic [4:0]  reg_waddr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_wen_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(QDEPTH);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [QDEPTH];
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pending_q, pending_d;
  logic [4:0]      waddr_q, waddr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            wen_q, wen_d;

  logic            ex_valid;
  logic            q_empty;
  logic            lu_enq_ok;
  logic            bypass;
  logic            deq;
  logic            enq;
  entry_t          head;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  assign lu_ready_o = rst & (count_q != C_FULL);
  assign ex_valid   = ex_wen_i & (ex_waddr_i != 5'd0);
  assign q_empty    = (count_q == '0);
  // x0 results still complete the handshake but are never stored.
  assign lu_enq_ok  = lu_valid_i & lu_ready_o & (lu_waddr_i != 5'd0);
  assign head       = mem_q[rptr_q];

`ifdef WB_BYPASS_EN
  assign bypass = ~ex_valid & q_empty & lu_enq_ok;
`else
  assign bypass = 1'b0;
`endif

  assign deq = ~ex_valid & ~q_empty;
  assign enq = lu_enq_ok & ~bypass;

  assign stall_o = rst & ((pending_q[id_rs1_i] & (id_rs1_i != 5'd0)) |
                          (pending_q[id_rs2_i] & (id_rs2_i != 5'd0)) |
                          (pending_q[id_rd_i]  & (id_rd_i  != 5'd0)));

  always_comb begin
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wen_d    = 1'b0;
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    count_d  = count_q;
    set_mask = '0;
    clr_mask = '0;

    if (ex_valid) begin
      waddr_d = ex_waddr_i;
      wdata_d = ex_wdata_i;
      wen_d   = 1'b1;
    end else if (deq) begin
      waddr_d = head.addr;
      wdata_d = head.data;
      wen_d   = 1'b1;
      clr_mask[head.addr] = 1'b1;
    end else if (bypass) begin
      waddr_d = lu_waddr_i;
      wdata_d = lu_wdata_i;
      wen_d   = 1'b1;
      clr_mask[lu_waddr_i] = 1'b1;
    end

    if (deq) rptr_d = rptr_q + PW'(1);
    if (enq) wptr_d = wptr_q + PW'(1);
    if (enq && !deq)      count_d = count_q + CW'(1);
    else if (deq && !enq) count_d = count_q - CW'(1);

    if (iss_long_i && iss_rd_i != 5'd0) set_mask[iss_rd_i] = 1'b1;
    // A new issue to the register being retired must stay pending.
    pending_d = ((pending_q & ~clr_mask) | set_mask) & 32'hFFFF_FFFE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      pending_q <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wen_q     <= 1'b0;
    end else begin
      rptr_q    <= rptr_d;
      wptr_q    <= wptr_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && enq) mem_q[wptr_q] <= '{addr: lu_waddr_i, data: lu_wdata_i};
  end

  assign reg_waddr_o = waddr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wen_o   = wen_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wb_ctrl: directed self-checking bench for wb_ctrl.
// Revision: 1.0
// ============================================================================
module tb_wb_ctrl;

`ifdef WB_BYPASS_EN
  localparam bit C_BYP = 1'b1;
`else
  localparam bit C_BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        ex_wen_i;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  iss_rd_i;
  logic        iss_long_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
  logic        stall_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_wen_o;

  int errors = 0;
  int checks = 0;

  wb_ctrl #(.QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_wen_i(ex_wen_i),
    .lu_waddr_i(lu_waddr_i), .lu_wdata_i(lu_wdata_i), .lu_valid_i(lu_valid_i),
    .lu_ready_o(lu_ready_o),
    .iss_rd_i(iss_rd_i), .iss_long_i(iss_long_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .stall_o(stall_o),
    .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o), .reg_wen_o(reg_wen_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_wen_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lu_valid_i = 0; lu_waddr_i = 0; lu_wdata_i = 0;
    iss_long_i = 0; iss_rd_i = 0;
    id_rs1_i = 0; id_rs2_i = 0; id_rd_i = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    step();
    step();
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o, lu_ready_o, stall_o} !== 40'd0) begin
      errors++;
      $display("FAIL reset_hold wen=%0b addr=%0d data=%h ready=%0b stall=%0b required all 0",
               reg_wen_o, reg_waddr_o, reg_wdata_o, lu_ready_o, stall_o);
    end
    rst = 1;
    #1;
    checks++;
    if ({lu_ready_o, stall_o, reg_wen_o} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release ready=%0b stall=%0b wen=%0b required 1/0/0",
               lu_ready_o, stall_o, reg_wen_o);
    end
  endtask

  task automatic test_ex_write();
    ex_wen_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hDEADBEEF;
    step();
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL ex_x5 wen=%0b addr=%0d data=%h required 1/5/deadbeef",
               reg_wen_o, reg_waddr_o, reg_wdata_o);
    end
    ex_waddr_i = 0; ex_wdata_i = 32'h1;
    // x0 lu result completes the handshake but must be discarded.
    lu_valid_i = 1; lu_waddr_i = 0; lu_wdata_i = 32'hBAD0;
    step();
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL ex_x0 wen=%0b addr=%0d data=%h required 0/5/deadbeef (held)",
               reg_wen_o, reg_waddr_o, reg_wdata_o);
    end
    idle_inputs();
    step();
    checks++;
    if (reg_wen_o !== 1'b0) begin
      errors++;
      $display("FAIL x0_lu_discard wen=%0b required 0", reg_wen_o);
    end
  endtask

  task automatic test_long_op();
    iss_long_i = 1; iss_rd_i = 7; id_rs1_i = 7;
    step();
    iss_long_i = 0; iss_rd_i = 0;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_set stall=%0b required 1", stall_o);
    end
    lu_valid_i = 1; lu_waddr_i = 7; lu_wdata_i = 32'h12345678;
    step();
    lu_valid_i = 0;
    if (!C_BYP) begin
      checks++;
      if ({reg_wen_o, stall_o} !== 2'b01) begin
        errors++;
        $display("FAIL long_wait wen=%0b stall=%0b required 0/1", reg_wen_o, stall_o);
      end
      step();
    end
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o} !== {1'b1, 5'd7, 32'h12345678, 1'b0}) begin
      errors++;
      $display("FAIL long_write wen=%0b addr=%0d data=%h stall=%0b required 1/7/12345678/0",
               reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    ex_wen_i = 1; ex_waddr_i = 1;
    for (int i = 0; i < 6; i++) begin
      ex_wdata_i = 32'h100 + i;
      lu_valid_i = 1;
      lu_waddr_i = 5'(2 + acc);
      lu_wdata_i = 32'h200 + 32'(2 + acc);
      #1;
      checks++;
      if (lu_ready_o !== (acc < 4)) begin
        errors++;
        $display("FAIL starve_ready cyc=%0d ready=%0b required %0b", i, lu_ready_o, acc < 4);
      end
      step();
      if (acc < 4) acc++;
      checks++;
      if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'd1, 32'h100 + 32'(i)}) begin
        errors++;
        $display("FAIL ex_stream cyc=%0d wen=%0b addr=%0d data=%h required 1/1/%h",
                 i, reg_wen_o, reg_waddr_o, reg_wdata_o, 32'h100 + 32'(i));
      end
    end
    ex_wen_i = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (k == 0) begin
        checks++;
        if (lu_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL ready_rise ready=%0b required 1", lu_ready_o);
        end
      end
      if (k == 1) lu_valid_i = 0;
      checks++;
      if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== {1'b1, 5'(2 + k), 32'h200 + 32'(2 + k)}) begin
        errors++;
        $display("FAIL drain k=%0d wen=%0b addr=%0d data=%h required 1/%0d/%h",
                 k, reg_wen_o, reg_waddr_o, reg_wdata_o, 2 + k, 32'h200 + 32'(2 + k));
      end
    end
    idle_inputs();
    step();
    checks++;
    if (reg_wen_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_done wen=%0b required 0", reg_wen_o);
    end
  endtask

  task automatic test_same_cycle();
    ex_wen_i = 1; ex_waddr_i = 3; ex_wdata_i = 32'h33;
    lu_valid_i = 1; lu_waddr_i = 4; lu_wdata_i = 32'h44;
    iss_long_i = 1; iss_rd_i = 4;
    id_rd_i = 4;
    step();
    ex_wen_i = 0; lu_valid_i = 0; iss_long_i = 0;
    #1;
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o} !== {1'b1, 5'd3, 32'h33, 1'b1}) begin
      errors++;
      $display("FAIL same_ex wen=%0b addr=%0d data=%h stall=%0b required 1/3/33/1",
               reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o);
    end
    step();
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o} !== {1'b1, 5'd4, 32'h44, 1'b0}) begin
      errors++;
      $display("FAIL same_lu wen=%0b addr=%0d data=%h stall=%0b required 1/4/44/0",
               reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_drain();
    ex_wen_i = 1; ex_waddr_i = 1;
    for (int i = 0; i < 3; i++) begin
      ex_wdata_i = 32'h300 + i;
      lu_valid_i = 1; lu_waddr_i = 5'(8 + i); lu_wdata_i = 32'h800 + i;
      iss_long_i = 1; iss_rd_i = 5'(8 + i);
      step();
    end
    idle_inputs();
    id_rs1_i = 9; id_rs2_i = 10; id_rd_i = 8;
    #1;
    checks++;
    if (stall_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_flush_stall stall=%0b required 1", stall_o);
    end
    rst = 0;
    step();
    checks++;
    if ({reg_wen_o, reg_waddr_o, reg_wdata_o, lu_ready_o, stall_o} !== 40'd0) begin
      errors++;
      $display("FAIL flush wen=%0b addr=%0d data=%h ready=%0b stall=%0b required all 0",
               reg_wen_o, reg_waddr_o, reg_wdata_o, lu_ready_o, stall_o);
    end
    rst = 1;
    #1;
    checks++;
    if ({stall_o, lu_ready_o} !== 2'b01) begin
      errors++;
      $display("FAIL flush_release stall=%0b ready=%0b required 0/1", stall_o, lu_ready_o);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (reg_wen_o !== 1'b0) begin
        errors++;
        $display("FAIL stale_write k=%0d wen=%0b addr=%0d required wen 0", k, reg_wen_o, reg_waddr_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ex_write();
    test_long_op();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_ctrl.md
# wb_ctrl

Write-back controller that owns the single register-file write port (address, data, enable). It merges single-cycle results from EX with out-of-order results from long-latency units (loads, multiply/divide) through a small pending-result queue. It also keeps a per-register scoreboard of outstanding long-latency destinations so ID can stall on RAW and WAW hazards. It sits between EX/long-latency units and the register file, which writes on the rising clock edge and internally bypasses same-cycle writes to its read ports.

## Interface
- QDEPTH, 4: long-latency result queue depth; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- ex_waddr_i  in  5  EX destination register.
- ex_wdata_i  in  32  EX result.
- ex_wen_i  in  1  EX write request; cannot be back-pressured.
- lu_waddr_i  in  5  long-latency result destination.
- lu_wdata_i  in  32  long-latency result data.
- lu_valid_i  in  1  long-latency result valid.
- lu_ready_o  out  1  queue can accept; a transfer occurs when valid and ready are both high on a clock edge.
- iss_rd_i  in  5  destination of an instruction issued this cycle.
- iss_long_i  in  1  issued instruction is long-latency; marks iss_rd_i pending.
- id_rs1_i, id_rs2_i, id_rd_i  in  5 each  registers used by the instruction in ID.
- stall_o  out  1  ID must hold: pending[rs1] | pending[rs2] | pending[rd], x0 excluded.
- reg_waddr_o  out  5  register-file write address.
- reg_wdata_o  out  32  register-file write data.
- reg_wen_o  out  1  register-file write enable.

## Operation
- State: QDEPTH×37-bit circular queue with read pointer, write pointer, and count (width clog2(QDEPTH)+1); 32-bit pending mask; registered write-port outputs.
- Reset (rst=0 at an edge): queue empty, pointers and count 0, pending mask 0, reg_waddr_o=0, reg_wdata_o=0, reg_wen_o=0. lu_ready_o=0 while rst=0; stall_o=0 while rst=0.
- ex_valid = ex_wen_i & (ex_waddr_i != 0). EX writes to x0 are dropped.
- Port arbitration each cycle, fixed priority:
  - ex_valid: output register loads the EX address and data with wen=1.
  - Otherwise, queue non-empty: dequeue the head entry into the output register with wen=1.
  - Otherwise: wen=0; address and data hold their previous values.
- Enqueue: lu_valid_i & lu_ready_o & lu_waddr_i != 0. A result addressed to x0 is accepted (handshake completes) and discarded.
- lu_ready_o = rst & (count != QDEPTH). It is combinational from count only and does not depend on lu_valid_i.
- Enqueue and dequeue in the same cycle: count unchanged. Pointers wrap modulo QDEPTH.
- Scoreboard:
  - iss_long_i & iss_rd_i != 0 sets pending[iss_rd_i].
  - Driving reg_wen_o=1 to address A from a dequeued or bypassed long-latency entry clears pending[A]. EX writes never clear pending bits.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - pending[0] is never set.
- ID stalls on pending[rd], so at most one outstanding long-latency write exists per register. Queue order does not need to follow issue order.

## Timing
- EX write at edge N drives reg_* starting at edge N+1, one cycle latency, every cycle without loss.
- Long-latency result accepted at edge N, with queue empty and no EX write at N+1: reg_* driven after edge N+1, latency 2 (1 with WB_BYPASS_EN).
- Continuous EX writes starve the queue. lu_ready_o drops when count reaches QDEPTH and rises the cycle after the first dequeue.
- stall_o is combinational from the current pending mask and ID addresses. Issue at edge N makes stall_o assert for dependent ID addresses in cycle N+1.
- The pending bit clears on the same edge reg_wen_o rises. stall_o deasserts in that cycle, while the register file is writing, and its bypass supplies the data.

## Configuration
- WB_BYPASS_EN defined: in a cycle with no ex_valid and an empty queue, an enqueue-qualifying long-latency result loads the output register directly and clears its pending bit, without entering the queue. Long-latency latency is 1.
- Undefined: every long-latency result passes through the queue. Minimum latency is 2; all other behaviour is identical.

## Test plan
- Reset with rst=0 for 2 cycles, then release: all outputs 0; lu_ready_o=1 in the first cycle after release; stall_o=0.
- EX write x5=0xDEADBEEF, then x0=0x1: reg_wen_o=1 with x5/0xDEADBEEF for one cycle, then reg_wen_o=0; x0 is never driven.
- Issue long op to x7 with ID rs1=x7: stall_o=1. Deliver lu x7=0x12345678 with EX idle: reg_* shows x7/0x12345678 after 2 cycles (1 with bypass), and stall_o=0 that cycle.
- Hold ex_wen_i=1 to x1 for 6 cycles while pushing 5 lu results to x2..x6: lu_ready_o=0 after 4 accepts. Once EX stops, x2..x5 drain in order, then x6; no EX write is lost.
- Same-cycle EX write x3, lu result x4, issue long x4: EX x3 written first, x4 written the next cycle, and pending[x4] ends 0.
- Assert reset mid-drain with 3 entries queued: the queue flushes, pending is cleared, reg_wen_o=0 the following cycle, and no stale entry is written after release.
